// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
//   Serial asynchronous transmitter fed from the read port of a FIFO. Whenever
//   transmission is enabled and the FIFO holds a word, the head word is captured,
//   popped and shifted out on txd as a start bit, DATA_WIDTH data bits LSB first,
//   an optional parity bit and STOP_BITS stop bits. Consecutive frames follow with
//   no idle gap while words remain and enable stays high.
//
// Ports
//   clock      : system clock, all state on the rising edge
//   reset_n    : asynchronous active-low reset
//   enable     : 1 = new frames may start; 0 = finish the current frame, then idle
//   fifo_dout  : FIFO head word, valid while fifo_empty = 0
//   fifo_empty : FIFO empty flag
//   fifo_read  : registered one-clock pop strobe to the FIFO
//   txd        : serial output, idle/mark = 1
//   busy       : high from the first start-bit clock through the last stop-bit clock
//   tx_done    : one-clock pulse on the clock after the final stop-bit clock
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_WIDTH   = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_read,
    output logic                  txd,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int             TW        = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0]  BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     LAST_DATA = 3'(DATA_WIDTH - 1);
    localparam logic [2:0]     LAST_STOP = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [TW-1:0]           timer;
    logic [2:0]              bit_idx;
    logic [DATA_WIDTH-1:0]   shift;
    logic                    par_bit;

    logic bit_end;
    logic last_stop;
    logic start_frame;

    // A bit boundary is the last clock of the current bit period.
    assign bit_end     = (timer == '0);
    assign last_stop   = (state == S_STOP) && bit_end && (bit_idx == LAST_STOP);
    // A new frame may begin from idle or seamlessly at the end of the last stop bit.
    assign start_frame = enable && !fifo_empty && ((state == S_IDLE) || last_stop);

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_frame) state_nxt = S_START;
            end
            S_START: begin
                if (bit_end) state_nxt = S_DATA;
            end
            S_DATA: begin
                if (bit_end && (bit_idx == LAST_DATA))
                    state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (bit_end) state_nxt = S_STOP;
            end
            S_STOP: begin
                if (last_stop) state_nxt = start_frame ? S_START : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        txd  = 1'b1;
        busy = (state != S_IDLE);
        case (state)
            S_START:  txd = 1'b0;
            S_DATA:   txd = shift[0];
            S_PARITY: txd = par_bit;
            default:  txd = 1'b1;
        endcase
    end

    // Bit timer, bit index and the registered strobes
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            timer     <= '0;
            bit_idx   <= '0;
            fifo_read <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            fifo_read <= start_frame;
            tx_done   <= last_stop;

            if (state_nxt == S_IDLE)
                timer <= '0;
            else if (start_frame || bit_end)
                timer <= BIT_LAST;
            else
                timer <= timer - 1'b1;

            // The index restarts on every state change and counts data and stop bits.
            if (state_nxt != state)
                bit_idx <= '0;
            else if (bit_end && ((state == S_DATA) || (state == S_STOP)))
                bit_idx <= bit_idx + 1'b1;
        end
    end

    // Frame payload: captured once per frame, shifted at data bit boundaries
    always_ff @(posedge clock) begin
        if (start_frame) begin
            shift   <= fifo_dout;
            par_bit <= (PARITY == 1) ? ~^fifo_dout : ^fifo_dout;
        end else if ((state == S_DATA) && bit_end) begin
            shift <= shift >> 1;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Testbench for fifo_uart_tx. Four framings run in parallel against one shared
// clock; each has its own FIFO model, expected-frame scoreboard and a serial
// monitor that reconstructs frames from txd.
module tb_fifo_uart_tx;

    localparam int NCFG = 4;
    localparam int CK_A [NCFG] = '{4, 4, 5, 2};
    localparam int DW_A [NCFG] = '{8, 8, 8, 5};
    localparam int PA_A [NCFG] = '{0, 2, 1, 2};
    localparam int SB_A [NCFG] = '{1, 2, 1, 2};

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int errors  = 0;
    int checks  = 0;
    int fin_cnt = 0;

    task automatic check(input int cfg, input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL cfg%0d %s: got %0d expected %0d", cfg, name, act, exp);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : cfg
        localparam int CPB   = CK_A[g];
        localparam int DW    = DW_A[g];
        localparam int PAR   = PA_A[g];
        localparam int SB    = SB_A[g];
        localparam int NBITS = 1 + DW + ((PAR != 0) ? 1 : 0) + SB;
        localparam int FRAME = NBITS * CPB;
        localparam logic [7:0] MASK = 8'((1 << DW) - 1);

        logic          reset_n    = 1'b0;
        logic          enable     = 1'b0;
        logic          fifo_empty = 1'b1;
        logic [DW-1:0] fifo_dout  = '0;
        logic          fifo_read;
        logic          txd;
        logic          busy;
        logic          tx_done;

        fifo_uart_tx #(
            .CLKS_PER_BIT(CPB),
            .DATA_WIDTH  (DW),
            .PARITY      (PAR),
            .STOP_BITS   (SB)
        ) dut (
            .clock     (clock),
            .reset_n   (reset_n),
            .enable    (enable),
            .fifo_dout (fifo_dout),
            .fifo_empty(fifo_empty),
            .fifo_read (fifo_read),
            .txd       (txd),
            .busy      (busy),
            .tx_done   (tx_done)
        );

        logic [7:0] fq[$];
        logic [7:0] expq[$];
        int pops = 0;

        function automatic void fifo_sync();
            fifo_empty = (fq.size() == 0);
            fifo_dout  = (fq.size() != 0) ? DW'(fq[0]) : '0;
        endfunction

        // Reference frame: start 0, data LSB first, optional parity, stop ones.
        function automatic logic [15:0] frame_bits(input logic [7:0] b);
            logic [15:0] f;
            logic        p;
            f = '0;
            p = 1'b0;
            for (int i = 0; i < DW; i++) begin
                f[1 + i] = b[i];
                p = p ^ b[i];
            end
            if (PAR == 1) p = ~p;
            if (PAR != 0) f[1 + DW] = p;
            for (int s = 0; s < SB; s++) f[1 + DW + ((PAR != 0) ? 1 : 0) + s] = 1'b1;
            return f;
        endfunction

        // FIFO model: the head is removed during the cycle the strobe is high.
        always @(negedge clock) begin
            if (fifo_read) begin
                if (fq.size() == 0) check(g, "pop_from_empty", 1, 0);
                else void'(fq.pop_front());
                pops++;
                fifo_sync();
            end
        end

        // Serial monitor
        int          pos = 0;
        logic [15:0] got = '0;
        bit          glitch = 1'b0;
        bit          busy_bad = 1'b0;
        bit          done_due = 1'b0;

        always @(negedge clock) begin
            if (!reset_n) begin
                pos      = 0;
                done_due = 1'b0;
            end else begin
                if (done_due || tx_done) check(g, "tx_done", int'(tx_done), int'(done_due));
                done_due = 1'b0;
                if (pos == 0) begin
                    if (txd == 1'b0) begin
                        got      = '0;
                        glitch   = 1'b0;
                        busy_bad = !busy;
                        pos      = 1;
                    end else begin
                        check(g, "idle_busy", int'(busy), 0);
                    end
                end else begin
                    if ((pos % CPB) == 0) got[pos / CPB] = txd;
                    else if (txd != got[pos / CPB]) glitch = 1'b1;
                    if (!busy) busy_bad = 1'b1;
                    pos++;
                    if (pos == FRAME) begin
                        if (expq.size() == 0) begin
                            check(g, "unexpected_frame", int'(got), -1);
                        end else begin
                            check(g, "frame_bits", int'(got), int'(frame_bits(expq.pop_front())));
                            check(g, "bit_stable", int'(glitch), 0);
                            check(g, "busy_in_frame", int'(busy_bad), 0);
                        end
                        pos      = 0;
                        done_due = 1'b1;
                    end
                end
            end
        end

        task automatic tick(input int n);
            repeat (n) @(negedge clock);
            #1;
        endtask

        task automatic push(input logic [7:0] b, input bit expect_tx);
            fq.push_back(b & MASK);
            fifo_sync();
            if (expect_tx) expq.push_back(b & MASK);
        endtask

        task automatic wait_busy();
            int n;
            n = 0;
            while (!busy && n < 20) begin
                tick(1);
                n++;
            end
            check(g, "start_seen", int'(busy), 1);
        endtask

        task automatic wait_idle(input int budget);
            int n;
            n = 0;
            while ((busy || pos != 0 || expq.size() != 0) && n < budget) begin
                tick(1);
                n++;
            end
            check(g, "drained", (busy || pos != 0 || expq.size() != 0) ? 0 : 1, 1);
            tick(2);
        endtask

        initial begin : stim
            int         p0;
            int         run;
            logic [7:0] b;

            tick(2);
            check(g, "reset_txd", int'(txd), 1);
            check(g, "reset_busy", int'(busy), 0);
            check(g, "reset_fifo_read", int'(fifo_read), 0);
            check(g, "reset_tx_done", int'(tx_done), 0);
            reset_n = 1'b1;
            tick(2);
            enable = 1'b1;

            // single frames, including the parity reference byte
            p0 = pops;
            push(8'h55, 1'b1);
            wait_idle(FRAME * 3);
            push(8'h07, 1'b1);
            wait_idle(FRAME * 3);
            check(g, "pops_single", pops - p0, 2);

            // back-to-back frames with no idle gap
            p0 = pops;
            push(8'hA3, 1'b1);
            push(8'h0F, 1'b1);
            wait_busy();
            run = 0;
            while (busy && run < 4 * FRAME) begin
                run++;
                tick(1);
            end
            check(g, "busy_run", run, 2 * FRAME);
            wait_idle(FRAME * 3);
            check(g, "pops_b2b", pops - p0, 2);

            // disabled with data waiting: nothing leaves until enable returns
            enable = 1'b0;
            p0 = pops;
            b = 8'($urandom);
            push(b, 1'b0);
            tick(100);
            check(g, "pops_disabled", pops - p0, 0);
            check(g, "fifo_kept", fq.size(), 1);
            enable = 1'b1;
            expq.push_back(b & MASK);
            wait_idle(FRAME * 3);
            check(g, "pops_reenabled", pops - p0, 1);

            // enable dropped mid-frame: frame completes, no next pop
            p0 = pops;
            b = 8'($urandom);
            push(8'($urandom) ^ 8'h3C, 1'b1);
            push(b, 1'b0);
            wait_busy();
            tick(5);
            enable = 1'b0;
            wait_idle(FRAME * 3);
            tick(FRAME);
            check(g, "pops_drop_enable", pops - p0, 1);
            check(g, "fifo_left", fq.size(), 1);
            enable = 1'b1;
            expq.push_back(b & MASK);
            wait_idle(FRAME * 3);

            // reset during data bit 3 abandons the frame at once
            p0 = pops;
            push(8'($urandom), 1'b1);
            wait_busy();
            tick(4 * CPB + 1);
            reset_n = 1'b0;
            #1;
            check(g, "midreset_txd", int'(txd), 1);
            check(g, "midreset_busy", int'(busy), 0);
            check(g, "midreset_fifo_read", int'(fifo_read), 0);
            check(g, "midreset_tx_done", int'(tx_done), 0);
            expq.delete();
            tick(3);
            reset_n = 1'b1;
            tick(50);
            check(g, "pops_after_reset", pops - p0, 1);
            push(8'($urandom), 1'b1);
            wait_idle(FRAME * 3);
            check(g, "pops_clean_frame", pops - p0, 2);

            // empty FIFO for a long stretch: no strobe, line stays at mark
            p0 = pops;
            tick(1000);
            check(g, "pops_empty", pops - p0, 0);
            check(g, "empty_txd", int'(txd), 1);

            // random bytes at random spacing
            p0 = pops;
            for (int k = 0; k < 8; k++) begin
                push(8'($urandom), 1'b1);
                tick($urandom_range(0, FRAME * 2));
            end
            wait_idle(FRAME * 12 + 100);
            check(g, "pops_random", pops - p0, 8);
            check(g, "fifo_drained", fq.size(), 0);

            fin_cnt++;
        end
    end

    initial begin : summary
        int n;
        n = 0;
        while (fin_cnt < NCFG && n < 90000) begin
            @(posedge clock);
            n++;
        end
        if (fin_cnt < NCFG) check(-1, "global_timeout", fin_cnt, NCFG);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
